core_jmp_resolve_multi: RTL and testbench
=========================================

Name: core_jmp_resolve_multi

Overview:
- Multi-lane branch resolution unit for the execute stage. Generalises the single-lane jump checker to LANES parallel branch units.
- Per lane, each cycle: resolves the true direction, computes the redirect PC, detects mispredicts and emits registered BPU training records.
- Arbitrates the oldest mispredict across lanes and over time into a one-entry redirect buffer with a valid/ready handshake to the frontend.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- LANES, 2, number of parallel branch lanes (1..4).
- XLEN, 32, datapath / PC width.
- ID_W, 6, instruction age-tag width. Tags are circular.
- META_W, 16, opaque BPU metadata width (lphr/history/ras_ptr). Passed through unchanged.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  backend flush. Kills the held redirect and all lanes this cycle.
- valid_i  in  LANES  lane holds a branch/jump
- branch_type_i  in  LANES*2  codebase `_BRANCH_*` encoding; anything else = not taken
- cmp_type_i  in  LANES*3  codebase `_CMP_*` encoding
- id_i  in  LANES*ID_W  age tag
- pc_i, target_i, r0_i, r1_i  in  LANES*XLEN each  PC, taken target, operands
- pred_taken_i  in  LANES  predicted direction
- pred_target_i  in  LANES*XLEN  predicted next PC when taken
- pred_meta_i  in  LANES*META_W  predictor metadata
- redirect_valid_o  out  1  redirect pending
- redirect_ready_i  in  1  frontend accepts the redirect
- redirect_pc_o  out  XLEN  correct next PC
- redirect_id_o  out  ID_W  tag of the mispredicting branch
- upd_valid_o  out  LANES  training record valid (registered)
- upd_miss_o, upd_taken_o  out  LANES each  mispredict flag, true direction
- upd_pc_o, upd_target_o  out  LANES*XLEN each  branch PC, true taken target
- upd_meta_o  out  LANES*META_W  metadata echo
- br_cnt_o, miss_cnt_o  out  CNT_W each  resolved branches, mispredicts

Behaviour:
- Interface: one clock `clk`. Reset is synchronous and active-high (`rst`).
- Reset: all outputs 0; redirect buffer empty; counters 0.
- Per-lane resolve (combinational):
  - `_BRANCH_NOCONDITION` -> taken = 1.
  - `_BRANCH_CONDITION` -> compare per cmp_type:
    - E, NE: equality on raw operands.
    - LT, GE, LE, GT: signed; both operands sign-extended to XLEN+1.
    - LTU, GEU: unsigned.
  - next_pc = taken ? target_i : pc_i+4, modulo 2^XLEN.
  - miss = valid & (pred_taken != taken | (taken & pred_target != target_i)).
  - A correctly predicted not-taken branch is never a miss.
- Age rule: a is older than b iff (b-a) mod 2^ID_W lies in [1, 2^(ID_W-1)-1]. Equal tags never occur on distinct live lanes.
- Kill rule: a valid lane is killed if any of the following holds:
  - flush_i is high;
  - it is younger than the held redirect (while redirect_valid_o is high and the redirect has not fired this cycle);
  - it is younger than the oldest missing lane of the same cycle.
- Killed lanes produce no training record and no counter increment.
- Training stage, latency 1: each surviving valid lane registers upd_* at the next edge, with upd_valid_o = 1. Non-surviving lanes register upd_valid_o = 0.
- Candidate: the oldest surviving missing lane this cycle, if any.
- Redirect buffer (one entry). Update at the edge, in priority order:
  - rst or flush_i -> empty.
  - Empty, or firing this cycle (valid & ready) -> load the candidate if present, otherwise empty.
  - Held, not firing -> replace only if the candidate is strictly older than redirect_id_o. Otherwise hold unchanged and drop the candidate.
- Handshake:
  - Once raised, redirect_valid_o stays high until fire, flush or rst.
  - The payload changes while held only by replacement with an older redirect.
  - The frontend must sample the payload on the fire cycle.
- Counters:
  - br_cnt_o += number of surviving lanes.
  - miss_cnt_o += number of surviving missing lanes.
  - Both are registered, with the same timing as upd_*. Both saturate at 2^CNT_W-1 and never wrap.
- rst asserted mid-redirect discards the redirect with no fire.

Test Plan:
- Lane0: BEQ, r0=r1=5, pc=0x1000, target=0x1040, pred taken to 0x1040 -> no redirect; next cycle upd_valid=1, upd_miss=0, upd_taken=1; br_cnt=1, miss_cnt=0.
- Lane0: BLT, r0=0xFFFFFFFF, r1=1, pred not-taken, target=0x2000 -> taken; redirect_pc=0x2000 the next cycle. Same inputs as BLTU -> not taken, no miss.
- Lane0 id=5 and lane1 id=3 both miss (lane1 pc=0x300, pred taken, true not-taken) -> redirect_id=3, redirect_pc=0x304; lane0 killed, upd_valid=2'b10, miss_cnt=1.
- Redirect id=10 held with ready=0. A lane misses with id=12 -> dropped and killed, no update. A lane misses with id=8 -> payload replaced by id 8. Then ready=1 -> one fire, buffer empty.
- Tags wrap at ID_W=6: held id=62, a lane misses with id=1 -> younger, dropped. A lane misses with id=60 -> older, replaced.
- flush_i during a pending redirect plus a new miss -> redirect_valid=0 next cycle, upd_valid=0, counters unchanged. With CNT_W=4 and miss_cnt=15, a further miss -> stays 15.

Source files
------------

// File: rtl/core_jmp_resolve_multi.sv
// Multi-lane branch resolve: training records and counters 1 cycle after resolve; oldest mispredict
// goes to a one-entry redirect buffer held until redirect_ready_i, replaced only by an older redirect.
module core_jmp_resolve_multi #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int ID_W   = 6,
  parameter int META_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        valid_i,
  input  logic [LANES*2-1:0]      branch_type_i,
  input  logic [LANES*3-1:0]      cmp_type_i,
  input  logic [LANES*ID_W-1:0]   id_i,
  input  logic [LANES*XLEN-1:0]   pc_i,
  input  logic [LANES*XLEN-1:0]   target_i,
  input  logic [LANES*XLEN-1:0]   r0_i,
  input  logic [LANES*XLEN-1:0]   r1_i,
  input  logic [LANES-1:0]        pred_taken_i,
  input  logic [LANES*XLEN-1:0]   pred_target_i,
  input  logic [LANES*META_W-1:0] pred_meta_i,
  output logic                    redirect_valid_o,
  input  logic                    redirect_ready_i,
  output logic [XLEN-1:0]         redirect_pc_o,
  output logic [ID_W-1:0]         redirect_id_o,
  output logic [LANES-1:0]        upd_valid_o,
  output logic [LANES-1:0]        upd_miss_o,
  output logic [LANES-1:0]        upd_taken_o,
  output logic [LANES*XLEN-1:0]   upd_pc_o,
  output logic [LANES*XLEN-1:0]   upd_target_o,
  output logic [LANES*META_W-1:0] upd_meta_o,
  output logic [CNT_W-1:0]        br_cnt_o,
  output logic [CNT_W-1:0]        miss_cnt_o
);

  localparam logic [1:0] BRANCH_NOCONDITION = 2'b01;
  localparam logic [1:0] BRANCH_CONDITION   = 2'b10;
  localparam logic [2:0] CMP_E = 3'd0, CMP_NE = 3'd1, CMP_LT = 3'd2, CMP_GE = 3'd3;
  localparam logic [2:0] CMP_LTU = 3'd4, CMP_GEU = 3'd5, CMP_LE = 3'd6, CMP_GT = 3'd7;
  localparam int SUM_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // a is older than b when b sits 1 .. 2^(ID_W-1)-1 steps ahead of a on the tag circle
  function automatic logic is_older(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
    logic [ID_W-1:0] d;
    d = b - a;
    return (d != '0) && !d[ID_W-1];
  endfunction

  logic [LANES-1:0]            taken, miss, kill, surv;
  logic [LANES-1:0][XLEN-1:0]  next_pc;
  logic [LANES-1:0][ID_W-1:0]  lane_id;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [XLEN-1:0] a, b, tgt;
    logic [1:0]      btype;
    logic [2:0]      ctype;
    logic            cond;

    assign a     = r0_i[g*XLEN +: XLEN];
    assign b     = r1_i[g*XLEN +: XLEN];
    assign tgt   = target_i[g*XLEN +: XLEN];
    assign btype = branch_type_i[g*2 +: 2];
    assign ctype = cmp_type_i[g*3 +: 3];

    always_comb begin
      cond = 1'b0;
      case (ctype)
        CMP_E:   cond = (a == b);
        CMP_NE:  cond = (a != b);
        CMP_LT:  cond = $signed({a[XLEN-1], a}) <  $signed({b[XLEN-1], b});
        CMP_GE:  cond = $signed({a[XLEN-1], a}) >= $signed({b[XLEN-1], b});
        CMP_LE:  cond = $signed({a[XLEN-1], a}) <= $signed({b[XLEN-1], b});
        CMP_GT:  cond = $signed({a[XLEN-1], a}) >  $signed({b[XLEN-1], b});
        CMP_LTU: cond = (a <  b);
        CMP_GEU: cond = (a >= b);
        default: cond = 1'b0;
      endcase
    end

    assign taken[g]   = (btype == BRANCH_NOCONDITION) | ((btype == BRANCH_CONDITION) & cond);
    assign next_pc[g] = taken[g] ? tgt : pc_i[g*XLEN +: XLEN] + XLEN'(4);
    assign lane_id[g] = id_i[g*ID_W +: ID_W];
    assign miss[g]    = valid_i[g] & ((pred_taken_i[g] != taken[g]) |
                        (taken[g] & (pred_target_i[g*XLEN +: XLEN] != tgt)));
  end

  logic                   red_vld_q, red_vld_d;
  logic [XLEN-1:0]        red_pc_q, red_pc_d;
  logic [ID_W-1:0]        red_id_q, red_id_d;
  logic [LANES-1:0]       upd_valid_q, upd_valid_d, upd_miss_q, upd_miss_d, upd_taken_q, upd_taken_d;
  logic [LANES*XLEN-1:0]  upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic [LANES*META_W-1:0] upd_meta_q, upd_meta_d;
  logic [CNT_W-1:0]       br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                   fire, hold_live, cand_vld;
  logic [XLEN-1:0]        cand_pc;
  logic [ID_W-1:0]        cand_id;
  logic [2:0]             br_inc, miss_inc;
  logic [SUM_W-1:0]       br_sum, miss_sum;

  assign fire      = red_vld_q & redirect_ready_i;
  assign hold_live = red_vld_q & ~redirect_ready_i;

  // Any missing lane older than a lane kills it; tags within a cycle lie in a narrow window
  always_comb begin
    kill = '0;
    for (int i = 0; i < LANES; i++) begin
      kill[i] = flush_i | (hold_live & is_older(red_id_q, lane_id[i]));
      for (int j = 0; j < LANES; j++)
        if (miss[j] && is_older(lane_id[j], lane_id[i])) kill[i] = 1'b1;
    end
  end

  assign surv = valid_i & ~kill;

  always_comb begin
    cand_vld = 1'b0;
    cand_pc  = '0;
    cand_id  = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (surv[i] && miss[i]) begin
        cand_vld = 1'b1;
        cand_pc  = next_pc[i];
        cand_id  = lane_id[i];
      end
  end

  always_comb begin
    red_vld_d = red_vld_q;
    red_pc_d  = red_pc_q;
    red_id_d  = red_id_q;
    if (flush_i) begin
      red_vld_d = 1'b0;
    end else if (!red_vld_q || fire) begin
      red_vld_d = cand_vld;
      red_pc_d  = cand_pc;
      red_id_d  = cand_id;
    end else if (cand_vld && is_older(cand_id, red_id_q)) begin
      red_pc_d  = cand_pc;
      red_id_d  = cand_id;
    end
  end

  always_comb begin
    upd_valid_d  = surv;
    upd_miss_d   = surv & miss;
    upd_taken_d  = taken;
    upd_pc_d     = pc_i;
    upd_target_d = target_i;
    upd_meta_d   = pred_meta_i;
    br_inc       = '0;
    miss_inc     = '0;
    for (int i = 0; i < LANES; i++) begin
      br_inc   += 3'(surv[i]);
      miss_inc += 3'(surv[i] & miss[i]);
    end
    br_sum     = SUM_W'(br_cnt_q) + SUM_W'(br_inc);
    miss_sum   = SUM_W'(miss_cnt_q) + SUM_W'(miss_inc);
    br_cnt_d   = (br_sum   > SUM_W'(CNT_MAX)) ? CNT_MAX : br_sum[CNT_W-1:0];
    miss_cnt_d = (miss_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : miss_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_vld_q    <= 1'b0;
      red_pc_q     <= '0;
      red_id_q     <= '0;
      upd_valid_q  <= '0;
      upd_miss_q   <= '0;
      upd_taken_q  <= '0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_meta_q   <= '0;
      br_cnt_q     <= '0;
      miss_cnt_q   <= '0;
    end else begin
      red_vld_q    <= red_vld_d;
      red_pc_q     <= red_pc_d;
      red_id_q     <= red_id_d;
      upd_valid_q  <= upd_valid_d;
      upd_miss_q   <= upd_miss_d;
      upd_taken_q  <= upd_taken_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_meta_q   <= upd_meta_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign redirect_valid_o = red_vld_q;
  assign redirect_pc_o    = red_pc_q;
  assign redirect_id_o    = red_id_q;
  assign upd_valid_o      = upd_valid_q;
  assign upd_miss_o       = upd_miss_q;
  assign upd_taken_o      = upd_taken_q;
  assign upd_pc_o         = upd_pc_q;
  assign upd_target_o     = upd_target_q;
  assign upd_meta_o       = upd_meta_q;
  assign br_cnt_o         = br_cnt_q;
  assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: tb/tb_core_jmp_resolve_multi.sv
// Bench for core_jmp_resolve_multi: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model; a CNT_W=4 instance exercises counter saturation.
`timescale 1ns/1ps
module tb_core_jmp_resolve_multi;
  localparam int LANES = 2, XLEN = 32, ID_W = 6, META_W = 16;
  localparam bit [1:0] BR_NC = 2'b01, BR_C = 2'b10;
  localparam bit [2:0] C_E = 0, C_NE = 1, C_LT = 2, C_GE = 3, C_LTU = 4, C_GEU = 5, C_LE = 6, C_GT = 7;

  logic clk = 0, rst = 1, flush_i = 0, redirect_ready_i = 0;
  logic [LANES-1:0] valid_i = '0, pred_taken_i = '0;
  logic [LANES*2-1:0] branch_type_i = '0;
  logic [LANES*3-1:0] cmp_type_i = '0;
  logic [LANES*ID_W-1:0] id_i = '0;
  logic [LANES*XLEN-1:0] pc_i = '0, target_i = '0, r0_i = '0, r1_i = '0, pred_target_i = '0;
  logic [LANES*META_W-1:0] pred_meta_i = '0;

  logic redirect_valid_o, s_rv;
  logic [XLEN-1:0] redirect_pc_o, s_rpc;
  logic [ID_W-1:0] redirect_id_o, s_rid;
  logic [LANES-1:0] upd_valid_o, upd_miss_o, upd_taken_o, s_uv, s_um, s_ut;
  logic [LANES*XLEN-1:0] upd_pc_o, upd_target_o, s_upc, s_utg;
  logic [LANES*META_W-1:0] upd_meta_o, s_umeta;
  logic [31:0] br_cnt_o, miss_cnt_o;
  logic [3:0] s_br, s_miss;

  always #5 clk = ~clk;

  core_jmp_resolve_multi #(.LANES(LANES), .XLEN(XLEN), .ID_W(ID_W), .META_W(META_W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .branch_type_i(branch_type_i),
    .cmp_type_i(cmp_type_i), .id_i(id_i), .pc_i(pc_i), .target_i(target_i), .r0_i(r0_i), .r1_i(r1_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .pred_meta_i(pred_meta_i),
    .redirect_valid_o(redirect_valid_o), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(redirect_pc_o), .redirect_id_o(redirect_id_o), .upd_valid_o(upd_valid_o),
    .upd_miss_o(upd_miss_o), .upd_taken_o(upd_taken_o), .upd_pc_o(upd_pc_o),
    .upd_target_o(upd_target_o), .upd_meta_o(upd_meta_o), .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o));

  core_jmp_resolve_multi #(.LANES(LANES), .XLEN(XLEN), .ID_W(ID_W), .META_W(META_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .branch_type_i(branch_type_i),
    .cmp_type_i(cmp_type_i), .id_i(id_i), .pc_i(pc_i), .target_i(target_i), .r0_i(r0_i), .r1_i(r1_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .pred_meta_i(pred_meta_i),
    .redirect_valid_o(s_rv), .redirect_ready_i(redirect_ready_i),
    .redirect_pc_o(s_rpc), .redirect_id_o(s_rid), .upd_valid_o(s_uv),
    .upd_miss_o(s_um), .upd_taken_o(s_ut), .upd_pc_o(s_upc),
    .upd_target_o(s_utg), .upd_meta_o(s_umeta), .br_cnt_o(s_br), .miss_cnt_o(s_miss));

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit older(int a, int b);
    int d;
    d = (((b - a) % 64) + 64) % 64;
    return d >= 1 && d <= 31;
  endfunction

  function automatic bit ref_taken(bit [1:0] bt, bit [2:0] c, bit [31:0] a, bit [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    if (bt == BR_NC) return 1'b1;
    if (bt != BR_C) return 1'b0;
    case (c)
      C_E:   return a == b;
      C_NE:  return a != b;
      C_LT:  return sa < sb;
      C_GE:  return sa >= sb;
      C_LE:  return sa <= sb;
      C_GT:  return sa > sb;
      C_LTU: return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  bit m_rv = 0;
  bit [31:0] m_rpc = 0;
  bit [5:0] m_rid = 0;
  bit [1:0] m_uv = 0;
  bit [81:0] m_rec [LANES];
  longint m_br = 0, m_miss = 0;
  bit tk [LANES], ms [LANES], sv [LANES];
  bit [31:0] npc [LANES];
  int lid [LANES];
  int oldest, cand;
  bit fire;

  always @(posedge clk) begin
    if (rst) begin
      m_rv = 0; m_rpc = 0; m_rid = 0; m_uv = 0; m_br = 0; m_miss = 0;
    end else begin
      fire = m_rv && redirect_ready_i;
      for (int i = 0; i < LANES; i++) begin
        lid[i] = int'(id_i[i*ID_W +: ID_W]);
        tk[i]  = ref_taken(branch_type_i[i*2 +: 2], cmp_type_i[i*3 +: 3], r0_i[i*32 +: 32], r1_i[i*32 +: 32]);
        npc[i] = tk[i] ? target_i[i*32 +: 32] : pc_i[i*32 +: 32] + 32'd4;
        ms[i]  = valid_i[i] && (pred_taken_i[i] != tk[i] ||
                 (tk[i] && pred_target_i[i*32 +: 32] != target_i[i*32 +: 32]));
      end
      oldest = -1;
      for (int i = 0; i < LANES; i++)
        if (ms[i] && (oldest < 0 || older(lid[i], lid[oldest]))) oldest = i;
      cand = -1;
      for (int i = 0; i < LANES; i++) begin
        sv[i] = valid_i[i] && !flush_i && !(m_rv && !fire && older(int'(m_rid), lid[i])) &&
                !(oldest >= 0 && older(lid[oldest], lid[i]));
        if (sv[i] && ms[i] && (cand < 0 || older(lid[i], lid[cand]))) cand = i;
      end
      if (flush_i) m_rv = 0;
      else if (!m_rv || fire) begin
        m_rv = (cand >= 0);
        if (cand >= 0) begin m_rpc = npc[cand]; m_rid = 6'(lid[cand]); end
      end else if (cand >= 0 && older(lid[cand], int'(m_rid))) begin
        m_rpc = npc[cand]; m_rid = 6'(lid[cand]);
      end
      for (int i = 0; i < LANES; i++) begin
        m_uv[i] = sv[i];
        m_rec[i] = {ms[i], tk[i], pc_i[i*32 +: 32], target_i[i*32 +: 32], pred_meta_i[i*16 +: 16]};
        if (sv[i]) begin m_br++; if (ms[i]) m_miss++; end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("redirect_valid", redirect_valid_o, m_rv);
    if (m_rv) begin
      chk("redirect_pc", redirect_pc_o, m_rpc);
      chk("redirect_id", redirect_id_o, m_rid);
    end
    chk("upd_valid", upd_valid_o, m_uv);
    for (int i = 0; i < LANES; i++)
      if (m_uv[i])
        chk("upd_record", {upd_miss_o[i], upd_taken_o[i], upd_pc_o[i*32 +: 32],
            upd_target_o[i*32 +: 32], upd_meta_o[i*16 +: 16]}, m_rec[i]);
    chk("br_cnt", br_cnt_o, sat(m_br, 32));
    chk("miss_cnt", miss_cnt_o, sat(m_miss, 32));
    chk("sat_br_cnt", s_br, sat(m_br, 4));
    chk("sat_miss_cnt", s_miss, sat(m_miss, 4));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear();
    valid_i = '0; pred_taken_i = '0; branch_type_i = '0; cmp_type_i = '0; id_i = '0;
  endtask

  task automatic set_lane(input int l, input bit [1:0] bt, input bit [2:0] ct, input bit [5:0] id,
                          input bit [31:0] pc, input bit [31:0] tgt, input bit [31:0] a, input bit [31:0] b,
                          input bit pt, input bit [31:0] ptg, input bit [15:0] meta);
    valid_i[l] = 1'b1;
    branch_type_i[l*2 +: 2] = bt;
    cmp_type_i[l*3 +: 3] = ct;
    id_i[l*ID_W +: ID_W] = id;
    pc_i[l*32 +: 32] = pc;
    target_i[l*32 +: 32] = tgt;
    r0_i[l*32 +: 32] = a;
    r1_i[l*32 +: 32] = b;
    pred_taken_i[l] = pt;
    pred_target_i[l*32 +: 32] = ptg;
    pred_meta_i[l*16 +: 16] = meta;
  endtask

  function automatic bit [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom_range(0, 7);
    endcase
  endfunction

  int base = 0;
  int o0, o1, tmp;
  bit [31:0] pc_r, tgt_r;

  initial begin
    rst = 1;
    repeat (2) cyc();
    rst = 0;
    chk("reset_state", {redirect_valid_o, upd_valid_o, br_cnt_o, miss_cnt_o}, '0);

    // correctly predicted taken BEQ
    clear(); set_lane(0, BR_C, C_E, 0, 32'h1000, 32'h1040, 5, 5, 1, 32'h1040, 16'hAAAA);
    cyc();
    chk("beq_hit", {redirect_valid_o, upd_valid_o, upd_miss_o[0], upd_taken_o[0]}, {1'b0, 2'b01, 1'b0, 1'b1});
    chk("beq_cnt", {br_cnt_o, miss_cnt_o}, {32'd1, 32'd0});

    // signed BLT taken, predicted not taken
    clear(); set_lane(0, BR_C, C_LT, 1, 32'h1100, 32'h2000, 32'hFFFF_FFFF, 1, 0, 0, 16'h1);
    cyc();
    chk("blt_redirect", {redirect_valid_o, redirect_pc_o, redirect_id_o}, {1'b1, 32'h2000, 6'd1});
    chk("blt_upd", {upd_valid_o[0], upd_miss_o[0], upd_taken_o[0]}, 3'b111);

    // same operands as BLTU: not taken, no miss; redirect fires this cycle
    clear(); redirect_ready_i = 1;
    set_lane(0, BR_C, C_LTU, 2, 32'h1100, 32'h2000, 32'hFFFF_FFFF, 1, 0, 0, 16'h2);
    cyc();
    chk("bltu_upd", {redirect_valid_o, upd_valid_o, upd_miss_o[0], upd_taken_o[0]}, {1'b0, 2'b01, 1'b0, 1'b0});
    redirect_ready_i = 0;

    // two lanes miss in one cycle; lane1 (id 3) is older
    clear();
    set_lane(0, BR_NC, C_E, 5, 32'h400, 32'h500, 0, 0, 0, 0, 16'h5);
    set_lane(1, BR_C, C_E, 3, 32'h300, 32'h340, 1, 2, 1, 32'h340, 16'h3);
    cyc();
    chk("dual_redirect", {redirect_valid_o, redirect_pc_o, redirect_id_o}, {1'b1, 32'h304, 6'd3});
    chk("dual_upd", {upd_valid_o, br_cnt_o, miss_cnt_o}, {2'b10, 32'd4, 32'd2});

    // fire held id 3 while loading a new miss with id 10
    clear(); redirect_ready_i = 1;
    set_lane(0, BR_NC, C_E, 10, 32'hA00, 32'hA80, 0, 0, 0, 0, 16'hA);
    cyc();
    chk("load_id10", {redirect_valid_o, redirect_pc_o, redirect_id_o}, {1'b1, 32'hA80, 6'd10});
    redirect_ready_i = 0;
    clear(); set_lane(0, BR_NC, C_E, 12, 32'hC00, 32'hC80, 0, 0, 0, 0, 16'hC);
    cyc();
    chk("younger_dropped", {redirect_valid_o, redirect_id_o, upd_valid_o}, {1'b1, 6'd10, 2'b00});
    clear(); set_lane(0, BR_NC, C_E, 8, 32'h800, 32'h880, 0, 0, 0, 0, 16'h8);
    cyc();
    chk("older_replaces", {redirect_valid_o, redirect_pc_o, redirect_id_o, upd_valid_o}, {1'b1, 32'h880, 6'd8, 2'b01});
    clear(); redirect_ready_i = 1;
    cyc();
    chk("fire_empties", redirect_valid_o, 1'b0);
    redirect_ready_i = 0;

    // tag wrap-around
    clear(); set_lane(0, BR_NC, C_E, 62, 32'h3E00, 32'h3E80, 0, 0, 0, 0, 16'h3E);
    cyc();
    chk("load_id62", {redirect_valid_o, redirect_id_o}, {1'b1, 6'd62});
    clear(); set_lane(0, BR_NC, C_E, 1, 32'h100, 32'h180, 0, 0, 0, 0, 16'h1);
    cyc();
    chk("wrap_younger", {redirect_valid_o, redirect_id_o, upd_valid_o}, {1'b1, 6'd62, 2'b00});
    clear(); set_lane(0, BR_NC, C_E, 60, 32'h3C00, 32'h3C80, 0, 0, 0, 0, 16'h3C);
    cyc();
    chk("wrap_older", {redirect_valid_o, redirect_pc_o, redirect_id_o}, {1'b1, 32'h3C80, 6'd60});

    // flush with a pending redirect and a new miss
    clear(); flush_i = 1;
    set_lane(0, BR_NC, C_E, 59, 32'h3B00, 32'h3B80, 0, 0, 0, 0, 16'h3B);
    cyc();
    chk("flush", {redirect_valid_o, upd_valid_o, br_cnt_o, miss_cnt_o}, {1'b0, 2'b00, 32'd8, 32'd6});
    flush_i = 0;

    // random traffic, with one reset pulse in the middle
    for (int n = 0; n < 3000; n++) begin
      clear();
      base = (base + $urandom_range(0, 3)) % 64;
      o0 = $urandom_range(0, 3);
      o1 = o0 + 1 + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin tmp = o0; o0 = o1; o1 = tmp; end
      for (int l = 0; l < LANES; l++) begin
        if ($urandom_range(0, 3) != 0) begin
          pc_r  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
          tgt_r = $urandom & 32'hFFFF_FFFC;
          set_lane(l, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   6'((base + ((l == 0) ? o0 : o1)) % 64), pc_r, tgt_r, pick_op(), pick_op(),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? tgt_r : $urandom,
                   16'($urandom));
        end
      end
      redirect_ready_i = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 31) == 0);
      rst = (n == 1500 || n == 1501);
      cyc();
    end
    clear(); flush_i = 0; rst = 0; redirect_ready_i = 0;
    repeat (2) cyc();
    chk("sat_pinned", {s_br, s_miss}, {4'hF, 4'hF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
